// File: rtl/audio_player.sv
// PCM playback from the shared ping/pong sample RAM into a 1-bit first-order sigma-delta (PDM) output.
// Optional macro AUDIO_PLAYER_UNDERRUN_HOLD_EN: on underrun keep the last sample instead of forcing midscale.
module audio_player #(
  parameter int DATA_WIDTH           = 16,
  parameter int SYS_CLK_FREQ_MHZ     = 100,
  parameter int SAMPLING_CLK_FREQ_HZ = 44100,
  parameter int PDM_CLK_DIV          = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  EN,
  input  logic                  ping_full,
  input  logic                  pong_full,
  output logic [10:0]           ram_addr,
  output logic                  ping_re,
  output logic                  pong_re,
  input  logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ping_done,
  output logic                  pong_done,
  output logic                  underrun,
  output logic                  pdm_out
);
  localparam int SAMPLE_DIV = SYS_CLK_FREQ_MHZ * 1000000 / SAMPLING_CLK_FREQ_HZ;
  localparam int SCW        = $clog2(SAMPLE_DIV);
  localparam int PCW        = $clog2(PDM_CLK_DIV);
  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, LATCH} state_t;

  state_t                state_q, state_d;
  logic [11:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] sample_u_q, sample_u_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  pdm_q, pdm_d;
  logic [SCW-1:0]        scnt_q, scnt_d;
  logic [PCW-1:0]        pcnt_q, pcnt_d;
  logic                  ping_done_q, ping_done_d;
  logic                  pong_done_q, pong_done_d;
  logic                  underrun_q, underrun_d;

  logic tick, pstb, cur_full;

  assign tick     = (scnt_q == SCW'(SAMPLE_DIV - 1));
  assign pstb     = (pcnt_q == PCW'(PDM_CLK_DIV - 1));
  assign cur_full = rd_ptr_q[11] ? pong_full : ping_full;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    sample_u_d  = sample_u_q;
    acc_d       = acc_q;
    pdm_d       = pdm_q;
    scnt_d      = tick ? '0 : scnt_q + SCW'(1);
    pcnt_d      = pstb ? '0 : pcnt_q + PCW'(1);
    ping_done_d = 1'b0;
    pong_done_d = 1'b0;
    underrun_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          if (cur_full) begin
            state_d = READ;
          end else begin
            underrun_d = 1'b1;
`ifndef AUDIO_PLAYER_UNDERRUN_HOLD_EN
            sample_u_d = MIDSCALE;
`endif
          end
        end
      end
      READ:  state_d = LATCH;
      LATCH: begin
        // Signed PCM to offset binary so the modulator sees an unsigned level.
        sample_u_d = ram_data_o ^ MIDSCALE;
        rd_ptr_d   = rd_ptr_q + 12'd1;
        if (rd_ptr_q[10:0] == 11'h7FF) begin
          ping_done_d = ~rd_ptr_q[11];
          pong_done_d = rd_ptr_q[11];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Carry out of the accumulator is the PDM bit.
    if (pstb) {pdm_d, acc_d} = {1'b0, acc_q} + {1'b0, sample_u_q};

    // Disabled playback parks every register at its reset value.
    if (!EN) begin
      state_d     = IDLE;
      rd_ptr_d    = '0;
      sample_u_d  = MIDSCALE;
      acc_d       = '0;
      pdm_d       = 1'b0;
      scnt_d      = '0;
      pcnt_d      = '0;
      ping_done_d = 1'b0;
      pong_done_d = 1'b0;
      underrun_d  = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      sample_u_q  <= MIDSCALE;
      acc_q       <= '0;
      pdm_q       <= 1'b0;
      scnt_q      <= '0;
      pcnt_q      <= '0;
      ping_done_q <= 1'b0;
      pong_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      sample_u_q  <= sample_u_d;
      acc_q       <= acc_d;
      pdm_q       <= pdm_d;
      scnt_q      <= scnt_d;
      pcnt_q      <= pcnt_d;
      ping_done_q <= ping_done_d;
      pong_done_q <= pong_done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ram_addr  = rd_ptr_q[10:0];
  assign ping_re   = (state_q == READ) & ~rd_ptr_q[11];
  assign pong_re   = (state_q == READ) &  rd_ptr_q[11];
  assign ping_done = ping_done_q;
  assign pong_done = pong_done_q;
  assign underrun  = underrun_q;
  assign pdm_out   = pdm_q;
endmodule

// File: tb/tb_audio_player.sv
// Directed bench for audio_player; sample period shortened to 16 cycles and PDM divider to 4.
module tb_audio_player;
  localparam int D    = 16;
  localparam int PDIV = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn, EN, ping_full, pong_full;
  logic [10:0] ram_addr;
  logic        ping_re, pong_re, ping_done, pong_done, underrun, pdm_out;
  logic [15:0] ram_data_o = '0;

  logic [15:0] ping_mem [2048];
  logic [15:0] pong_mem [2048];

  int passed = 0, total = 0;
  int n_ping_re, n_pong_re, n_ping_done, n_pong_done, n_under;
  int seq_err, excl_err, done_err;
  logic [11:0] exp_ptr = '0;
  logic        last_half;
  logic [10:0] last_addr;

  audio_player #(
    .DATA_WIDTH(16), .SYS_CLK_FREQ_MHZ(1), .SAMPLING_CLK_FREQ_HZ(62500), .PDM_CLK_DIV(PDIV)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .EN(EN), .ping_full(ping_full), .pong_full(pong_full),
    .ram_addr(ram_addr), .ping_re(ping_re), .pong_re(pong_re), .ram_data_o(ram_data_o),
    .ping_done(ping_done), .pong_done(pong_done), .underrun(underrun), .pdm_out(pdm_out)
  );

  always #5 HCLK = ~HCLK;

  // RAM model: data valid the cycle after the strobe.
  always @(posedge HCLK) begin
    if (ping_re)      ram_data_o <= ping_mem[ram_addr];
    else if (pong_re) ram_data_o <= pong_mem[ram_addr];
  end

  // Activity monitor with an independent read-pointer model.
  always @(negedge HCLK) begin
    if (!HRESETn || !EN) exp_ptr = '0;
    else begin
      if (ping_re && pong_re) excl_err++;
      if (ping_re || pong_re) begin
        if ({pong_re, ram_addr} != exp_ptr) seq_err++;
        exp_ptr   = exp_ptr + 12'd1;
        last_half = pong_re;
        last_addr = ram_addr;
        if (ping_re) n_ping_re++; else n_pong_re++;
      end
      if (ping_done) begin
        n_ping_done++;
        if (dut.sample_u_q !== (ping_mem[2047] ^ 16'h8000)) done_err++;
      end
      if (pong_done) begin
        n_pong_done++;
        if (dut.sample_u_q !== (pong_mem[2047] ^ 16'h8000)) done_err++;
      end
      if (underrun) n_under++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic clr_cnt();
    n_ping_re = 0; n_pong_re = 0; n_ping_done = 0; n_pong_done = 0; n_under = 0;
  endtask

  task automatic restart();
    EN = 1'b0;
    step(2);
    clr_cnt();
    EN = 1'b1;
  endtask

  // what: 0 = underrun pulse, 1 = any read strobe. n = edges counted since call.
  task automatic wait_for(input int what, input int max, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!((what == 0) ? underrun : (ping_re | pong_re)) && n < max);
  endtask

  function automatic logic [6:0] outs();
    return {ping_re, pong_re, ping_done, pong_done, underrun, pdm_out, |ram_addr};
  endfunction

  initial begin
    int n, alt, ones, u0;
    logic prev;
    logic [15:0] exp_hold;
    HRESETn = 1'b0; EN = 1'b0; ping_full = 1'b0; pong_full = 1'b0;
    seq_err = 0; excl_err = 0; done_err = 0;
    clr_cnt();
    for (int i = 0; i < 2048; i++) begin
      ping_mem[i] = (i < 4) ? 16'h7FFF : 16'(i * 3 + 1);
      pong_mem[i] = 16'(16'hA000 + i * 5);
    end

    // Reset state
    step(3);
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_sample", 32'(dut.sample_u_q), 32'h8000);
    chk("rst_ptr", 32'(dut.rd_ptr_q), 32'd0);
    HRESETn = 1'b1;
    step(2);
    chk("en_low_outs", 32'(outs()), 32'd0);

    // Empty buffers: underrun timing and midscale modulation
    clr_cnt();
    EN = 1'b1;
    wait_for(0, D + 10, n);
    chk("first_underrun_lat", 32'(n), 32'(D));
    prev = pdm_out; alt = 0;
    for (int i = 0; i < 8; i++) begin
      step(PDIV);
      if (pdm_out != prev) alt++;
      prev = pdm_out;
    end
    chk("pdm_alternate", 32'(alt), 32'd8);
    chk("no_strobe_empty", 32'(n_ping_re + n_pong_re), 32'd0);

    // Full-scale ping sample
    ping_full = 1'b1;
    restart();
    wait_for(1, D + 10, n);
    chk("first_read_lat", 32'(n), 32'(D));
    chk("first_read_sel", {30'd0, ping_re, pong_re}, 32'b10);
    chk("first_read_addr", 32'(ram_addr), 32'd0);
    step(2);
    chk("sample_ffff", 32'(dut.sample_u_q), 32'hFFFF);
    step(2 * PDIV);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (pdm_out) ones++;
      step(PDIV);
    end
    chk("pdm_fullscale", 32'(ones), 32'd8);

    // Consume ping with pong empty, then underruns parked at pong 0
    for (int k = 0; k < 2048 * D + 200 && n_ping_done == 0; k++) step(1);
    chk("ping_reads", 32'(n_ping_re), 32'd2048);
    chk("ping_done_once", 32'(n_ping_done), 32'd1);
    chk("no_pong_done", 32'(n_pong_done), 32'd0);
    u0 = n_under;
    step(3 * D);
    chk("underruns", 32'(n_under - u0), 32'd3);
    chk("park_ptr", 32'(dut.rd_ptr_q), 32'h800);
    chk("no_pong_read", 32'(n_pong_re), 32'd0);
`ifdef AUDIO_PLAYER_UNDERRUN_HOLD_EN
    exp_hold = 16'h97FE;
`else
    exp_hold = 16'h8000;
`endif
    chk("underrun_sample", 32'(dut.sample_u_q), 32'(exp_hold));

    // Pong becomes available, run through pong and wrap to ping 0
    pong_full = 1'b1;
    wait_for(1, D + 5, n);
    chk("pong_first_sel", {30'd0, ping_re, pong_re}, 32'b01);
    chk("pong_first_addr", 32'(ram_addr), 32'd0);
    for (int k = 0; k < 2048 * D + 200 && (n_ping_re + n_pong_re) < 4097; k++) step(1);
    chk("wrap_count", 32'(n_ping_re + n_pong_re), 32'd4097);
    chk("wrap_target", {20'd0, last_half, last_addr}, 32'd0);
    chk("pong_done_once", 32'(n_pong_done), 32'd1);
    chk("ping_done_total", 32'(n_ping_done), 32'd1);
    chk("seq_model", 32'(seq_err), 32'd0);
    chk("strobe_excl", 32'(excl_err), 32'd0);
    chk("done_sample", 32'(done_err), 32'd0);

    // Reset asserted during the READ cycle
    restart();
    wait_for(1, D + 5, n);
    chk("read_seen", {31'd0, ping_re}, 32'd1);
    HRESETn = 1'b0;
    step(1);
    chk("rst_read_outs", 32'(outs()), 32'd0);
    chk("rst_read_ptr", 32'(dut.rd_ptr_q), 32'd0);
    HRESETn = 1'b1;
    step(4);
    chk("rst_read_nolatch", 32'(dut.sample_u_q), 32'h8000);
    chk("rst_read_nodone", 32'(n_ping_done), 32'd0);

    // EN dropped mid-half restarts at ping 0 with no done
    restart();
    for (int k = 0; k < 101 * D + 100 && n_ping_re < 101; k++) step(1);
    chk("mid_reads", 32'(n_ping_re), 32'd101);
    EN = 1'b0;
    step(3);
    clr_cnt();
    EN = 1'b1;
    wait_for(1, D + 5, n);
    chk("reen_lat", 32'(n), 32'(D));
    chk("reen_addr", {20'd0, pong_re, ram_addr}, 32'd0);
    step(2 * D);
    chk("reen_nodone", 32'(n_ping_done), 32'd0);
    chk("seq_model_end", 32'(seq_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
